// File: rtl/mips_pkg.sv
// Shared MIPS I encodings and branch-unit state type.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_REGIMM  = 6'd1;
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_BLEZ    = 6'd6;
    localparam logic [5:0] OP_BGTZ    = 6'd7;

    localparam logic [5:0] RI_BLTZ    = 6'd0;
    localparam logic [5:0] RI_BGEZ    = 6'd1;
    localparam logic [5:0] RI_BLTZAL  = 6'd16;
    localparam logic [5:0] RI_BGEZAL  = 6'd17;

    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_JALR    = 6'd9;

    localparam logic [4:0] LINK_REG_RA = 5'd31;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } branch_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch/jump decode and condition evaluation.
// Jump encodings are recognised only when BRANCH_UNIT_JUMP_EN is defined.
module branch_cond_eval
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       opcode,
    input  logic [5:0]       b_code,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             is_branch,
    output logic             cond,
    output logic             is_link
);

    logic eq_s;
    logic zero_s;
    logic neg_s;

    // Operand comparisons shared by all conditions
    always_comb begin
        eq_s   = (rs_data == rt_data);
        zero_s = (rs_data == {WIDTH{1'b0}});
        neg_s  = rs_data[WIDTH-1];
    end

    // Opcode decode into branch class, condition and link request
    always_comb begin
        is_branch = 1'b0;
        cond      = 1'b0;
        is_link   = 1'b0;
        case (opcode)
            OP_BEQ:  begin is_branch = 1'b1; cond = eq_s;              end
            OP_BNE:  begin is_branch = 1'b1; cond = ~eq_s;             end
            OP_BLEZ: begin is_branch = 1'b1; cond = zero_s | neg_s;    end
            OP_BGTZ: begin is_branch = 1'b1; cond = ~zero_s & ~neg_s;  end
            OP_REGIMM: begin
                case (b_code)
                    RI_BLTZ:   begin is_branch = 1'b1; cond = neg_s;  end
                    RI_BGEZ:   begin is_branch = 1'b1; cond = ~neg_s; end
                    RI_BLTZAL: begin is_branch = 1'b1; cond = neg_s;  is_link = 1'b1; end
                    RI_BGEZAL: begin is_branch = 1'b1; cond = ~neg_s; is_link = 1'b1; end
                    default:   begin is_branch = 1'b0; cond = 1'b0;   is_link = 1'b0; end
                endcase
            end
`ifdef BRANCH_UNIT_JUMP_EN
            OP_J:   begin is_branch = 1'b1; cond = 1'b1; end
            OP_JAL: begin is_branch = 1'b1; cond = 1'b1; is_link = 1'b1; end
            OP_SPECIAL: begin
                case (funct)
                    FN_JR:   begin is_branch = 1'b1; cond = 1'b1; end
                    FN_JALR: begin is_branch = 1'b1; cond = 1'b1; is_link = 1'b1; end
                    default: begin is_branch = 1'b0; cond = 1'b0; is_link = 1'b0; end
                endcase
            end
`endif
            default: begin
                is_branch = 1'b0;
                cond      = 1'b0;
                is_link   = 1'b0;
            end
        endcase
    end

`ifndef BRANCH_UNIT_JUMP_EN
    logic unused_funct_s;
    assign unused_funct_s = ^funct;
`endif

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution with delay-slot tracking for the multicycle MIPS core.
// Optional feature macro: BRANCH_UNIT_JUMP_EN (J, JAL, JR, JALR).
module branch_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [5:0]       opcode,
    input  logic [5:0]       b_code,
    input  logic [5:0]       funct,
    input  logic [4:0]       rd,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] pc_next,
    output logic             taken,
    output logic             in_delay_slot,
    output logic             link_en,
    output logic [4:0]       link_reg,
    output logic [WIDTH-1:0] link_data,
    output logic             slot_err
);

    branch_state_t    state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             err_q, err_d;

    logic             is_branch_s;
    logic             cond_s;
    logic             is_link_s;
    logic             slot_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] br_tgt_s;
    logic [WIDTH-1:0] target_s;

    branch_cond_eval #(
        .WIDTH (WIDTH)
    ) u_cond (
        .opcode    (opcode),
        .b_code    (b_code),
        .funct     (funct),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .is_branch (is_branch_s),
        .cond      (cond_s),
        .is_link   (is_link_s)
    );

    // Target arithmetic; wrap-around mod 2^WIDTH is intentional
    always_comb begin
        pc_plus4_s = pc + WIDTH'(4);
        link_data  = pc + WIDTH'(8);
        br_tgt_s   = pc_plus4_s + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
        target_s   = br_tgt_s;
        link_reg   = LINK_REG_RA;
`ifdef BRANCH_UNIT_JUMP_EN
        case (opcode)
            OP_J, OP_JAL: target_s = (pc_plus4_s & ~WIDTH'(28'hFFF_FFFF))
                                   | WIDTH'({instr_index, 2'b00});
            OP_SPECIAL: begin
                target_s = rs_data;
                link_reg = rd;
            end
            default: target_s = br_tgt_s;
        endcase
`endif
    end

    // A branch in the delay slot is suppressed rather than evaluated
    always_comb begin
        slot_s        = (state_q == ST_SLOT);
        in_delay_slot = slot_s;
        taken         = is_branch_s & cond_s & ~slot_s;
        link_en       = advance & is_link_s & ~slot_s;
        pc_next       = slot_s ? tgt_q : pc_plus4_s;
        slot_err      = err_q;
    end

    // Next-state logic; nothing moves unless the instruction retires
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        if (advance) begin
            if (slot_s) begin
                state_d = ST_IDLE;
                err_d   = err_q | is_branch_s;
            end else if (taken) begin
                state_d = ST_SLOT;
                tgt_d   = target_s;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_q;
            tgt_d   = tgt_q;
            err_d   = err_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tgt_q   <= {WIDTH{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
        end
    end

`ifndef BRANCH_UNIT_JUMP_EN
    logic unused_jump_s;
    assign unused_jump_s = ^{rd, instr_index};
`endif

endmodule
